// File: rtl/dram_wbl_write_ctrl_if.sv
// -----------------------------------------------------------------------------
// dram_wbl_write_ctrl_if
//
// Bundles the signals between the write sequencer, the upstream key/S-box
// init stage and the DRAM CIM macro.
//
//   Request side (driven by the master, the upstream init stage):
//     IO_EN     write request pulse
//     ADDR      6-bit row address, captured with IO_EN
//     WBL_BUS   16 x 64-bit bitline words, bank b at [64b+63:64b]
//   Sequencer side (driven by the slave, dram_wbl_write_ctrl):
//     wr_done   one-cycle pulse when the full row has been written
//     BUSY      sequencer not idle
//     ROW_ADDR  latched row address to the macro
//     BANK_SEL  bank currently being written
//     WBL_OUT   bitline write data for BANK_SEL
//     WBL_EN    bitline drivers enabled
//     WL_EN     word-line enable
// -----------------------------------------------------------------------------
interface dram_wbl_write_ctrl_if;
  logic          IO_EN;
  logic [5:0]    ADDR;
  logic [1023:0] WBL_BUS;

  logic          wr_done;
  logic          BUSY;
  logic [5:0]    ROW_ADDR;
  logic [3:0]    BANK_SEL;
  logic [63:0]   WBL_OUT;
  logic          WBL_EN;
  logic          WL_EN;

  modport master (
    output IO_EN, ADDR, WBL_BUS,
    input  wr_done, BUSY, ROW_ADDR, BANK_SEL, WBL_OUT, WBL_EN, WL_EN
  );

  modport slave (
    input  IO_EN, ADDR, WBL_BUS,
    output wr_done, BUSY, ROW_ADDR, BANK_SEL, WBL_OUT, WBL_EN, WL_EN
  );
endinterface

// File: rtl/dram_wbl_write_ctrl.sv
// -----------------------------------------------------------------------------
// dram_wbl_write_ctrl
//
// Write sequencer between the key/S-box init stage and the DRAM CIM macro.
// One IO_EN pulse in IDLE captures a row address and 16 x 64-bit bitline
// words. The words are then driven bank by bank (0..15); every bank goes
// through SETUP (bitlines driven, T_SU cycles), PULSE (word line high, T_WL
// cycles) and HOLD (bitlines held, T_HD cycles). After bank 15 a DONE state
// produces a single-cycle wr_done and the block returns to IDLE.
//
// Parameters:
//   T_SU  bitline setup cycles before word-line rise   (1..15)
//   T_WL  word-line high cycles                        (1..15)
//   T_HD  bitline hold cycles after word-line fall     (1..15)
//
// Ports:
//   CLK     clock, rising edge
//   RSTn    asynchronous active-low reset
//   bus     dram_wbl_write_ctrl_if.slave (request inputs, macro-side outputs)
//   WR_ERR  sticky protocol error, present only when DRAM_WR_ERR_EN is defined
//
// Optional feature macro: DRAM_WR_ERR_EN
//   Defined   : WR_ERR is set by IO_EN arriving while BUSY and stays set
//               until RSTn. The request itself is still ignored.
//   Undefined : no WR_ERR port, IO_EN while busy is silently dropped.
//
// Timing for a request sampled at edge E0 (T = T_SU + T_WL + T_HD):
//   bank b word line high from E0+b*T+T_SU to E0+b*T+T_SU+T_WL,
//   wr_done during the cycle after edge E0+16T, IDLE again at E0+16T+1.
// -----------------------------------------------------------------------------
module dram_wbl_write_ctrl #(
  parameter int T_SU = 2,
  parameter int T_WL = 4,
  parameter int T_HD = 2
) (
  input  logic                   CLK,
  input  logic                   RSTn,
  dram_wbl_write_ctrl_if.slave   bus
`ifdef DRAM_WR_ERR_EN
  ,
  output logic                   WR_ERR
`endif
);

  localparam int NUM_BANKS = 16;
  localparam int WORD_W    = 64;

  // Terminal phase counts: the counter runs 0..T_x-1 inside each phase.
  localparam logic [3:0] SU_LAST   = 4'(T_SU - 1);
  localparam logic [3:0] WL_LAST   = 4'(T_WL - 1);
  localparam logic [3:0] HD_LAST   = 4'(T_HD - 1);
  localparam logic [3:0] BANK_LAST = 4'(NUM_BANKS - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SETUP = 3'd1,
    S_PULSE = 3'd2,
    S_HOLD  = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t             state_q, state_d;
  logic [3:0]         phase_q, phase_d;
  logic [3:0]         bank_q,  bank_d;
  logic [5:0]         addr_q,  addr_d;
  logic [WORD_W-1:0]  word_q [NUM_BANKS];
  logic [WORD_W-1:0]  word_d [NUM_BANKS];

  logic               capture;
  logic               active;

  // ---------------------------------------------------------------------------
  // Next-state, counters and capture
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    phase_d = phase_q + 4'd1;
    bank_d  = bank_q;
    addr_d  = addr_q;
    word_d  = word_q;
    capture = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        phase_d = '0;
        if (bus.IO_EN) begin
          capture = 1'b1;
          bank_d  = '0;
          state_d = S_SETUP;
        end
      end

      S_SETUP: begin
        if (phase_q == SU_LAST) begin
          phase_d = '0;
          state_d = S_PULSE;
        end
      end

      S_PULSE: begin
        if (phase_q == WL_LAST) begin
          phase_d = '0;
          state_d = S_HOLD;
        end
      end

      S_HOLD: begin
        if (phase_q == HD_LAST) begin
          phase_d = '0;
          if (bank_q == BANK_LAST) begin
            state_d = S_DONE;
          end else begin
            // Bank (and therefore WBL_OUT) only advances on SETUP entry, so
            // data is stable through the whole word-line window.
            bank_d  = bank_q + 4'd1;
            state_d = S_SETUP;
          end
        end
      end

      S_DONE: begin
        phase_d = '0;
        state_d = S_IDLE;
      end

      default: begin
        phase_d = '0;
        state_d = S_IDLE;
      end
    endcase

    // Only an IDLE request loads the row; later bus changes are invisible.
    if (capture) begin
      addr_d = bus.ADDR;
      for (int i = 0; i < NUM_BANKS; i++) begin
        word_d[i] = bus.WBL_BUS[i*WORD_W +: WORD_W];
      end
    end
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      state_q <= S_IDLE;
      phase_q <= '0;
      bank_q  <= '0;
      addr_q  <= '0;
      word_q  <= '{default: '0};
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      bank_q  <= bank_d;
      addr_q  <= addr_d;
      word_q  <= word_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Macro-side outputs, decoded from state so a reset drops them at once
  // ---------------------------------------------------------------------------
  assign active = (state_q == S_SETUP) || (state_q == S_PULSE) || (state_q == S_HOLD);

  assign bus.BUSY     = (state_q != S_IDLE);
  assign bus.wr_done  = (state_q == S_DONE);
  assign bus.WBL_EN   = active;
  assign bus.WL_EN    = (state_q == S_PULSE);
  assign bus.BANK_SEL = bank_q;
  assign bus.ROW_ADDR = addr_q;
  assign bus.WBL_OUT  = active ? word_q[bank_q] : '0;

`ifdef DRAM_WR_ERR_EN
  // ---------------------------------------------------------------------------
  // Sticky error: a request that arrives while any non-IDLE state is active
  // (DONE included) is dropped but remembered until reset.
  // ---------------------------------------------------------------------------
  logic err_q, err_d;

  always_comb begin
    err_d = err_q;
    if (bus.IO_EN && (state_q != S_IDLE)) begin
      err_d = 1'b1;
    end
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

  assign WR_ERR = err_q;
`endif

endmodule

// File: tb/tb_dram_wbl_write_ctrl.sv
// -----------------------------------------------------------------------------
// tb_dram_wbl_write_ctrl
//
// Two sequencer instances: dut0 with default timing (2/4/2) and dut1 with the
// fastest timing (1/1/1). Each row is traced cycle by cycle against a model
// that derives state from the elapsed cycle count since capture.
// -----------------------------------------------------------------------------
module tb_dram_wbl_write_ctrl;

  logic CLK  = 1'b0;
  logic RSTn = 1'b0;
  int   tests = 0;
  int   fails = 0;

  always #5 CLK = ~CLK;

  dram_wbl_write_ctrl_if bus0 ();
  dram_wbl_write_ctrl_if bus1 ();

`ifdef DRAM_WR_ERR_EN
  logic err0, err1;
`endif

  dram_wbl_write_ctrl #(.T_SU(2), .T_WL(4), .T_HD(2)) dut0 (
    .CLK  (CLK),
    .RSTn (RSTn),
    .bus  (bus0.slave)
`ifdef DRAM_WR_ERR_EN
    ,
    .WR_ERR (err0)
`endif
  );

  dram_wbl_write_ctrl #(.T_SU(1), .T_WL(1), .T_HD(1)) dut1 (
    .CLK  (CLK),
    .RSTn (RSTn),
    .bus  (bus1.slave)
`ifdef DRAM_WR_ERR_EN
    ,
    .WR_ERR (err1)
`endif
  );

  function automatic int tsu(input int sel); return (sel == 0) ? 2 : 1; endfunction
  function automatic int twl(input int sel); return (sel == 0) ? 4 : 1; endfunction
  function automatic int thd(input int sel); return (sel == 0) ? 2 : 1; endfunction

  // Reference: n cycles after the capture edge, which phase/bank are we in?
  function automatic void model(input int n, input int su, input int wl, input int hd,
                                output logic busy, output logic we, output logic wle,
                                output logic dn, output int bank);
    int t;
    t    = su + wl + hd;
    busy = 1'b0; we = 1'b0; wle = 1'b0; dn = 1'b0; bank = 0;
    if (n >= 0 && n < 16 * t) begin
      busy = 1'b1;
      we   = 1'b1;
      bank = n / t;
      wle  = ((n % t) >= su) && ((n % t) < su + wl);
    end else if (n == 16 * t) begin
      busy = 1'b1;
      dn   = 1'b1;
    end
  endfunction

  function automatic logic [1023:0] ramp_pattern();
    logic [1023:0] d;
    for (int b = 0; b < 16; b++) d[b*64 +: 64] = 64'h0101010101010101 * 64'(b + 1);
    return d;
  endfunction

  function automatic logic [1023:0] rand_pattern();
    logic [1023:0] d;
    for (int w = 0; w < 32; w++) d[w*32 +: 32] = $urandom();
    return d;
  endfunction

  task automatic drive(input int sel, input logic io, input logic [5:0] a, input logic [1023:0] d);
    if (sel == 0) begin
      bus0.IO_EN = io; bus0.ADDR = a; bus0.WBL_BUS = d;
    end else begin
      bus1.IO_EN = io; bus1.ADDR = a; bus1.WBL_BUS = d;
    end
  endtask

  task automatic sample(input int sel, output logic busy, output logic we, output logic wle,
                        output logic dn, output logic [3:0] bank, output logic [63:0] wout,
                        output logic [5:0] ra);
    if (sel == 0) begin
      busy = bus0.BUSY; we = bus0.WBL_EN; wle = bus0.WL_EN; dn = bus0.wr_done;
      bank = bus0.BANK_SEL; wout = bus0.WBL_OUT; ra = bus0.ROW_ADDR;
    end else begin
      busy = bus1.BUSY; we = bus1.WBL_EN; wle = bus1.WL_EN; dn = bus1.wr_done;
      bank = bus1.BANK_SEL; wout = bus1.WBL_OUT; ra = bus1.ROW_ADDR;
    end
  endtask

  // Issue one request from a negedge and trace it. rp_a/rp_b: cycle offsets at
  // which an extra (different) request is sampled; abort_at stops the trace.
  task automatic run_row(input int sel, input logic [5:0] addr, input logic [1023:0] data,
                         input int rp_a, input int rp_b, input bit ones_after, input int abort_at,
                         output int bad, output int pulses, output int done_at, output string msg);
    int t, last, e_bank;
    logic [5:0] cur_a, ra;
    logic [1023:0] cur_d;
    logic busy, we, wle, dn, prev_wl, e_busy, e_we, e_wl, e_dn;
    logic [3:0] bank;
    logic [63:0] wout, e_wout;
    t       = tsu(sel) + twl(sel) + thd(sel);
    last    = (abort_at >= 0) ? abort_at : 16 * t + 1;
    bad     = 0; pulses = 0; done_at = -1; msg = ""; prev_wl = 1'b0;
    cur_a   = addr; cur_d = data;
    drive(sel, 1'b1, cur_a, cur_d);
    @(posedge CLK);
    for (int n = 0; n <= last; n++) begin
      @(negedge CLK);
      sample(sel, busy, we, wle, dn, bank, wout, ra);
      model(n, tsu(sel), twl(sel), thd(sel), e_busy, e_we, e_wl, e_dn, e_bank);
      e_wout = e_we ? data[e_bank*64 +: 64] : 64'd0;
      if (wle && !prev_wl) pulses++;
      prev_wl = wle;
      if (dn && done_at < 0) done_at = n;
      if (busy !== e_busy || we !== e_we || wle !== e_wl || dn !== e_dn ||
          wout !== e_wout || ra !== addr || (e_we && bank !== 4'(e_bank))) begin
        if (bad == 0)
          msg = $sformatf("n=%0d busy=%b/%b wbl_en=%b/%b wl_en=%b/%b done=%b/%b bank=%0d/%0d row=%h/%h wbl_out=%h/%h",
                          n, busy, e_busy, we, e_we, wle, e_wl, dn, e_dn, bank, e_bank,
                          ra, addr, wout, e_wout);
        bad++;
      end
      if (ones_after && n == 0) cur_d = '1;
      if (n + 1 == rp_a || n + 1 == rp_b) begin
        cur_a = ~addr; cur_d = ~data;
        drive(sel, 1'b1, cur_a, cur_d);
      end else begin
        drive(sel, 1'b0, cur_a, cur_d);
      end
    end
  endtask

  task automatic test_reset();
    @(negedge CLK);
    tests++;
    if ({bus0.BUSY, bus0.wr_done, bus0.WBL_EN, bus0.WL_EN} !== 4'b0 ||
        bus0.BANK_SEL !== 4'd0 || bus0.ROW_ADDR !== 6'd0 || bus0.WBL_OUT !== 64'd0) begin
      fails++;
      $display("FAIL reset_dut0: busy/done/wbl_en/wl_en=%b%b%b%b bank=%0d row=%h out=%h, required all 0",
               bus0.BUSY, bus0.wr_done, bus0.WBL_EN, bus0.WL_EN, bus0.BANK_SEL, bus0.ROW_ADDR, bus0.WBL_OUT);
    end
    tests++;
    if ({bus1.BUSY, bus1.wr_done, bus1.WBL_EN, bus1.WL_EN} !== 4'b0 ||
        bus1.BANK_SEL !== 4'd0 || bus1.ROW_ADDR !== 6'd0 || bus1.WBL_OUT !== 64'd0) begin
      fails++;
      $display("FAIL reset_dut1: busy/done/wbl_en/wl_en=%b%b%b%b bank=%0d row=%h out=%h, required all 0",
               bus1.BUSY, bus1.wr_done, bus1.WBL_EN, bus1.WL_EN, bus1.BANK_SEL, bus1.ROW_ADDR, bus1.WBL_OUT);
    end
`ifdef DRAM_WR_ERR_EN
    tests++;
    if (err0 !== 1'b0 || err1 !== 1'b0) begin
      fails++;
      $display("FAIL reset_wr_err: got %b%b, required 00", err0, err1);
    end
`endif
    RSTn = 1'b1;
    @(negedge CLK);
  endtask

  task automatic test_default_row();
    int bad, pulses, done_at; string msg;
    run_row(0, 6'h2A, ramp_pattern(), -1, -1, 1'b0, -1, bad, pulses, done_at, msg);
    tests++;
    if (bad !== 0) begin fails++; $display("FAIL default_trace: %0d bad cycles, first %s", bad, msg); end
    tests++;
    if (pulses !== 16) begin fails++; $display("FAIL default_pulses: got %0d, required 16", pulses); end
    tests++;
    if (done_at !== 128) begin fails++; $display("FAIL default_done_at: got %0d, required 128", done_at); end
  endtask

  task automatic test_fast_timing();
    int bad, pulses, done_at; string msg;
    run_row(1, 6'h13, rand_pattern(), -1, -1, 1'b0, -1, bad, pulses, done_at, msg);
    tests++;
    if (bad !== 0) begin fails++; $display("FAIL fast_trace: %0d bad cycles, first %s", bad, msg); end
    tests++;
    if (pulses !== 16) begin fails++; $display("FAIL fast_pulses: got %0d, required 16", pulses); end
    tests++;
    if (done_at !== 48) begin fails++; $display("FAIL fast_done_at: got %0d, required 48", done_at); end
  endtask

  task automatic test_bus_change();
    int bad, pulses, done_at; string msg;
    run_row(0, 6'h07, rand_pattern(), -1, -1, 1'b1, -1, bad, pulses, done_at, msg);
    tests++;
    if (bad !== 0) begin fails++; $display("FAIL bus_change_trace: %0d bad cycles, first %s", bad, msg); end
  endtask

  task automatic test_busy_request();
    int bad, pulses, done_at; string msg;
`ifdef DRAM_WR_ERR_EN
    tests++;
    if (err0 !== 1'b0) begin fails++; $display("FAIL wr_err_before: got %b, required 0", err0); end
`endif
    run_row(0, 6'h15, rand_pattern(), 10, 129, 1'b0, -1, bad, pulses, done_at, msg);
    tests++;
    if (bad !== 0) begin fails++; $display("FAIL busy_req_trace: %0d bad cycles, first %s", bad, msg); end
    tests++;
    if (done_at !== 128) begin fails++; $display("FAIL busy_req_done_at: got %0d, required 128", done_at); end
    repeat (3) @(negedge CLK);
    tests++;
    if (bus0.BUSY !== 1'b0 || bus0.ROW_ADDR !== 6'h15) begin
      fails++;
      $display("FAIL busy_req_idle: busy=%b row=%h, required 0 and 15", bus0.BUSY, bus0.ROW_ADDR);
    end
`ifdef DRAM_WR_ERR_EN
    tests++;
    if (err0 !== 1'b1) begin fails++; $display("FAIL wr_err_sticky: got %b, required 1", err0); end
`endif
  endtask

  task automatic test_reset_mid_row();
    int bad, pulses, done_at, seen_done; string msg;
    run_row(0, 6'h31, rand_pattern(), -1, -1, 1'b0, 50, bad, pulses, done_at, msg);
    tests++;
    if (bad !== 0) begin fails++; $display("FAIL abort_trace: %0d bad cycles, first %s", bad, msg); end
    RSTn = 1'b0;
    #1;
    tests++;
    if ({bus0.BUSY, bus0.WBL_EN, bus0.WL_EN, bus0.wr_done} !== 4'b0 ||
        bus0.ROW_ADDR !== 6'd0 || bus0.WBL_OUT !== 64'd0) begin
      fails++;
      $display("FAIL abort_drop: busy/wbl_en/wl_en/done=%b%b%b%b row=%h out=%h, required all 0",
               bus0.BUSY, bus0.WBL_EN, bus0.WL_EN, bus0.wr_done, bus0.ROW_ADDR, bus0.WBL_OUT);
    end
`ifdef DRAM_WR_ERR_EN
    tests++;
    if (err0 !== 1'b0) begin fails++; $display("FAIL wr_err_reset: got %b, required 0", err0); end
`endif
    seen_done = 0;
    repeat (4) begin
      @(negedge CLK);
      if (bus0.wr_done !== 1'b0 || bus0.BUSY !== 1'b0) seen_done++;
    end
    tests++;
    if (seen_done !== 0) begin fails++; $display("FAIL abort_quiet: %0d active cycles in reset, required 0", seen_done); end
    RSTn = 1'b1;
    run_row(0, 6'h0C, rand_pattern(), -1, -1, 1'b0, -1, bad, pulses, done_at, msg);
    tests++;
    if (bad !== 0) begin fails++; $display("FAIL after_abort_trace: %0d bad cycles, first %s", bad, msg); end
  endtask

  // Upstream model: next IO_EN is registered one cycle after seeing wr_done,
  // which is exactly where run_row leaves off.
  task automatic test_back_to_back();
    int bad, pulses, done_at, bad_rows, done_ok; string msg, first_msg;
    bad_rows = 0; done_ok = 0; first_msg = "";
    for (int r = 0; r < 64; r++) begin
      run_row(0, 6'(r), rand_pattern(), -1, -1, 1'b0, -1, bad, pulses, done_at, msg);
      if (bad != 0) begin
        if (bad_rows == 0) first_msg = $sformatf("row %0d: %s", r, msg);
        bad_rows++;
      end
      if (done_at == 128 && pulses == 16) done_ok++;
    end
    tests++;
    if (bad_rows !== 0) begin fails++; $display("FAIL b2b_trace: %0d bad rows, first %s", bad_rows, first_msg); end
    tests++;
    if (done_ok !== 64) begin fails++; $display("FAIL b2b_done_count: got %0d, required 64", done_ok); end
  endtask

  initial begin
    drive(0, 1'b0, 6'd0, '0);
    drive(1, 1'b0, 6'd0, '0);
    test_reset();
    test_default_row();
    test_fast_timing();
    test_bus_change();
    test_busy_request();
    test_reset_mid_row();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
